// File: rtl/btn_pkg.sv
// Shared defaults and counter-width helpers for the push-button conditioner.
package btn_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int STUCK_CYCLES_DEF    = 1024;

    // Debounce counter must hold DEBOUNCE_CYCLES-1 plus headroom; stuck counter must hold STUCK_CYCLES.
    function automatic int deb_cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    function automatic int stuck_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int DEB_CNT_W_DEF   = deb_cnt_width(DEBOUNCE_CYCLES_DEF);
    localparam int STUCK_CNT_W_DEF = stuck_cnt_width(STUCK_CYCLES_DEF);

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, rising-edge pulse and,
// when BTN_STUCK_DETECT_EN is defined, a saturating stuck-press counter.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
`ifdef BTN_STUCK_DETECT_EN
    output logic stuck,
`endif
    output logic rise
);

    localparam int DEB_W = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_prev_r;
    logic             rise_r;
    logic             stable_next_s;
    logic [DEB_W-1:0] cnt_r;
    logic [DEB_W-1:0] cnt_next_s;

    // Two-flop synchronizer for the asynchronous button level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: any return to the stable level restarts the count
    always_comb begin
        stable_next_s = stable_r;
        cnt_next_s    = cnt_r;
        if (sync2_r == stable_r) begin
            cnt_next_s = {DEB_W{1'b0}};
        end else if (cnt_r == DEB_LAST) begin
            stable_next_s = ~stable_r;
            cnt_next_s    = {DEB_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + DEB_W'(1);
        end
    end

    // Stable level, debounce count and registered press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_r      <= 1'b0;
            stable_prev_r <= 1'b0;
            cnt_r         <= {DEB_W{1'b0}};
            rise_r        <= 1'b0;
        end else begin
            stable_r      <= stable_next_s;
            stable_prev_r <= stable_r;
            cnt_r         <= cnt_next_s;
            rise_r        <= stable_r & ~stable_prev_r;
        end
    end

    assign rise = rise_r;

`ifdef BTN_STUCK_DETECT_EN
    localparam int ST_W = stuck_cnt_width(STUCK_CYCLES);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(STUCK_CYCLES);

    logic [ST_W-1:0] stuck_cnt_r;

    // Count cycles spent stably pressed, saturating; a stable release clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            stuck_cnt_r <= {ST_W{1'b0}};
        end else if (!stable_next_s) begin
            stuck_cnt_r <= {ST_W{1'b0}};
        end else if (stuck_cnt_r != ST_MAX) begin
            stuck_cnt_r <= stuck_cnt_r + ST_W'(1);
        end else begin
            stuck_cnt_r <= stuck_cnt_r;
        end
    end

    assign stuck = (stuck_cnt_r == ST_MAX);
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Up/Down push-button conditioner feeding a queue counter; optional stuck detection
// is enabled by defining BTN_STUCK_DETECT_EN (default: Stuck_Flag tied low).
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic CLK,
    input  logic reset,
    input  logic Btn_Up_raw,
    input  logic Btn_Down_raw,
    output logic Up,
    output logic Down,
    output logic Stuck_Flag
);

    logic rise_up_s;
    logic rise_down_s;
    logic up_r;
    logic down_r;

`ifdef BTN_STUCK_DETECT_EN
    logic stuck_up_s;
    logic stuck_down_s;
    logic stuck_flag_r;
`endif

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_up (
        .clk   (CLK),
        .reset (reset),
        .raw   (Btn_Up_raw),
`ifdef BTN_STUCK_DETECT_EN
        .stuck (stuck_up_s),
`endif
        .rise  (rise_up_s)
    );

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_down (
        .clk   (CLK),
        .reset (reset),
        .raw   (Btn_Down_raw),
`ifdef BTN_STUCK_DETECT_EN
        .stuck (stuck_down_s),
`endif
        .rise  (rise_down_s)
    );

    // Simultaneous presses cancel so the queue sees no net change
    always_ff @(posedge CLK) begin
        if (reset) begin
            up_r   <= 1'b0;
            down_r <= 1'b0;
        end else begin
            up_r   <= rise_up_s & ~rise_down_s;
            down_r <= rise_down_s & ~rise_up_s;
        end
    end

    assign Up   = up_r;
    assign Down = down_r;

`ifdef BTN_STUCK_DETECT_EN
    // Registered OR of per-channel stuck indications
    always_ff @(posedge CLK) begin
        if (reset) begin
            stuck_flag_r <= 1'b0;
        end else begin
            stuck_flag_r <= stuck_up_s | stuck_down_s;
        end
    end

    assign Stuck_Flag = stuck_flag_r;
`else
    assign Stuck_Flag = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner at DEBOUNCE_CYCLES=4, STUCK_CYCLES=20.
module tb_btn_conditioner;

    localparam int DEB   = 4;
    localparam int STK   = 20;
    localparam int LAT   = 8;   // drive point -> pulse: 1 edge to first sample + DEB+3
    localparam int STLAT = 6;   // drive point -> stable level change: 1 + DEB+1
`ifdef BTN_STUCK_DETECT_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    typedef struct {
        int   cyc;
        logic up;
        logic dn;
    } exp_t;

    logic CLK = 1'b0;
    logic reset;
    logic Btn_Up_raw;
    logic Btn_Down_raw;
    logic Up;
    logic Down;
    logic Stuck_Flag;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    int   st_on = 0;
    int   st_off = 0;
    exp_t sb[$];

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .STUCK_CYCLES    (STK)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .Btn_Up_raw   (Btn_Up_raw),
        .Btn_Down_raw (Btn_Down_raw),
        .Up           (Up),
        .Down         (Down),
        .Stuck_Flag   (Stuck_Flag)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input int c, input logic up, input logic dn);
        exp_t e;
        e.cyc = c;
        e.up  = up;
        e.dn  = dn;
        sb.push_back(e);
    endtask

    // Expected stuck window from raw drive-high / drive-low points of a clean press
    task automatic note_press(input int dh, input int dl);
        int rise_c;
        int fall_c;
        rise_c = dh + STLAT;
        fall_c = dl + STLAT;
        if (STUCK_EN && (fall_c - rise_c >= STK)) begin
            st_on  = rise_c + STK;
            st_off = fall_c + 1;
        end
    endtask

    // Monitor: pops expected pulses whenever the DUT presents one
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("stuck_flag", {31'd0, Stuck_Flag}, {31'd0, (cyc >= st_on) && (cyc < st_off)});
            chk("up_down_exclusive", {31'd0, Up & Down}, 32'd0);
            if (Up || Down) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, Up, Down}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_kind", {30'd0, Up, Down}, {30'd0, e.up, e.dn});
                end
            end
        end
    end

    initial begin
        int c;
        reset        = 1'b1;
        Btn_Up_raw   = 1'b0;
        Btn_Down_raw = 1'b0;
        tick(3);
        chk("reset_up", {31'd0, Up}, 32'd0);
        chk("reset_down", {31'd0, Down}, 32'd0);
        chk("reset_stuck", {31'd0, Stuck_Flag}, 32'd0);
        mon_en = 1'b1;
        reset  = 1'b0;
        tick(2);

        // Clean Up press held 20 cycles
        c = cyc;
        Btn_Up_raw = 1'b1;
        push(c + LAT, 1'b1, 1'b0);
        note_press(c, c + 20);
        tick(20);
        Btn_Up_raw = 1'b0;
        tick(14);
        chk("drain_up_press", sb.size(), 32'd0);

        // Down bounces 1,0,1,0 then held
        Btn_Down_raw = 1'b1; tick(1);
        Btn_Down_raw = 1'b0; tick(1);
        Btn_Down_raw = 1'b1; tick(1);
        Btn_Down_raw = 1'b0; tick(1);
        c = cyc;
        Btn_Down_raw = 1'b1;
        push(c + LAT, 1'b0, 1'b1);
        note_press(c, c + 15);
        tick(15);
        Btn_Down_raw = 1'b0;
        tick(12);
        chk("drain_down_bounce", sb.size(), 32'd0);

        // Both pressed on the same edge: suppressed
        c = cyc;
        Btn_Up_raw   = 1'b1;
        Btn_Down_raw = 1'b1;
        note_press(c, c + 10);
        tick(10);
        Btn_Up_raw   = 1'b0;
        Btn_Down_raw = 1'b0;
        tick(12);
        chk("drain_both", sb.size(), 32'd0);

        // Press one cycle shorter than the debounce window: rejected
        Btn_Up_raw = 1'b1;
        tick(DEB - 1);
        Btn_Up_raw = 1'b0;
        tick(12);
        chk("drain_short", sb.size(), 32'd0);

        // Press exactly the debounce window: accepted
        c = cyc;
        Btn_Up_raw = 1'b1;
        push(c + LAT, 1'b1, 1'b0);
        tick(DEB);
        Btn_Up_raw = 1'b0;
        tick(12);
        chk("drain_min_press", sb.size(), 32'd0);

        // Reset at debounce count 2 with Up held through it
        Btn_Up_raw = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        chk("midreset_up", {31'd0, Up}, 32'd0);
        chk("midreset_down", {31'd0, Down}, 32'd0);
        tick(1);
        chk("midreset_up2", {31'd0, Up}, 32'd0);
        reset = 1'b0;
        c = cyc;
        push(c + LAT, 1'b1, 1'b0);
        note_press(c, c + 12);
        tick(12);
        Btn_Up_raw = 1'b0;
        tick(14);
        chk("drain_midreset", sb.size(), 32'd0);

        // Long Up hold: single pulse, stuck window when detection is built in
        c = cyc;
        Btn_Up_raw = 1'b1;
        push(c + LAT, 1'b1, 1'b0);
        note_press(c, c + 40);
        tick(40);
        Btn_Up_raw = 1'b0;
        tick(14);
        chk("drain_long_hold", sb.size(), 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required before a button level change is accepted.
REQ-002 Parameter STUCK_CYCLES, default 1024: continuous pressed cycles after which a button counts as stuck.
REQ-003 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port Btn_Up_raw  input  1  asynchronous, bouncy push-button level (1 = pressed).
REQ-006 Port Btn_Down_raw  input  1  asynchronous, bouncy push-button level (1 = pressed).
REQ-007 Port Up  output  1  one-cycle pulse per accepted Up press; feeds the queue counter's Up input.
REQ-008 Port Down  output  1  one-cycle pulse per accepted Down press; feeds the queue counter's Down input.
REQ-009 Port Stuck_Flag  output  1  high while either button is stuck pressed.

Function
REQ-010 Each raw input SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-011 Each channel SHALL hold a debounced stable level, per-channel debounce counter sized $clog2(DEBOUNCE_CYCLES)+1 bits.
REQ-012 Counter clears whenever synchronized level equals stable level; otherwise increments by 1 per cycle.
REQ-013 When counter would reach DEBOUNCE_CYCLES, stable level SHALL toggle and counter SHALL clear in the same edge.
REQ-014 Any bounce (synchronized level returning to stable level) before DEBOUNCE_CYCLES SHALL restart the count from 0.
REQ-015 Up/Down SHALL assert for exactly one cycle on a stable 0->1 transition, registered output.
REQ-016 Latency: a clean raw press held steady SHALL produce its pulse DEBOUNCE_CYCLES+3 rising edges after the first edge sampling it high.
REQ-017 Stable 1->0 (release) SHALL produce no pulse; holding a button SHALL produce no further pulses.
REQ-018 If both channels' stable 0->1 transitions occur in the same cycle, both Up and Down SHALL be suppressed for that cycle (net queue change zero).
REQ-019 Up and Down SHALL never be high in the same cycle.

Reset
REQ-020 While reset is high: synchronizer flops, stable levels, debounce and stuck counters SHALL load 0; Up, Down, Stuck_Flag SHALL be 0 on the next edge.
REQ-021 Reset mid-debounce SHALL discard the partial count; a button held through reset SHALL yield exactly one pulse, REQ-016 latency after reset deasserts.

Configuration
REQ-022 Macro BTN_STUCK_DETECT_EN defined: per-channel stuck counter counts cycles with stable level 1, saturates at STUCK_CYCLES; Stuck_Flag = OR of saturated channels; clears on that channel's stable release.
REQ-023 Macro BTN_STUCK_DETECT_EN undefined: no stuck counters synthesized; Stuck_Flag SHALL be tied 0; all other behaviour unchanged.

Structure
REQ-024 Shared package btn_pkg SHALL hold DEBOUNCE_CYCLES/STUCK_CYCLES defaults and derived counter-width constants.
REQ-025 One sub-module btn_channel (synchronizer, debounce counter, edge pulse, optional stuck counter) SHALL be instantiated twice; simultaneous-press suppression and Stuck_Flag OR live in btn_conditioner.

Verification (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20)
REQ-026 Btn_Up_raw 0->1 held 20 cycles -> single Up pulse 7 edges after first high sample; Down stays 0.
REQ-027 Btn_Down_raw toggles 1,0,1,0 each cycle then held 1 -> exactly one Down pulse, 7 edges after final steady high begins.
REQ-028 Both raw inputs rise same edge, held 10 cycles -> Up=0 and Down=0 throughout.
REQ-029 Btn_Up_raw held, reset asserted 2 cycles at debounce count 2 -> outputs 0 during reset, one Up pulse 7 edges after reset deasserts.
REQ-030 BTN_STUCK_DETECT_EN defined, Btn_Up_raw held 40 cycles -> Stuck_Flag rises 20 cycles after stable press, falls 1 edge after stable release; undefined -> Stuck_Flag constant 0.
